// File: rtl/instr_word_encoder_if.sv
// Request and instruction-memory write bus of the instruction word encoder.
// The master side issues symbolic requests and observes the memory writes
// and fill status; the slave side is the encoder itself.
interface instr_word_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              err;

  modport master (
    output in_valid, op_sel, rs, rt, rd, imm,
    input  in_ready, im_we, im_addr, im_wdata, word_count, full, err
  );

  modport slave (
    input  in_valid, op_sel, rs, rt, rd, imm,
    output in_ready, im_we, im_addr, im_wdata, word_count, full, err
  );
endinterface

// File: rtl/instr_word_encoder.sv
// Instruction word encoder: turns symbolic requests (add, sub, addi, lw, sw,
// mul) into 32-bit MIPS words and writes them to consecutive instruction
// memory addresses starting at BASE_ADDR, stopping once DEPTH words are in.
module instr_word_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 64
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   clr,
  instr_word_encoder_if.slave    bus
);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    FULL = 1'b1
  } stateT;

  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(BASE_ADDR + DEPTH - 1);

  stateT             state;
  stateT             stateNext;
  logic [ADDR_W-1:0] writePtr;
  logic [ADDR_W-1:0] imAddr;
  logic [ADDR_W:0]   wordCount;
  logic [31:0]       imWdata;
  logic              imWe;
  logic              errFlag;
  logic              lastWrite;
  logic              inReady;
  logic              accept;
  logic              legal;
  logic [31:0]       encoded;

  // op_sel 110/111 are not part of the decoder's subset.
  function automatic logic isLegalOp(input logic [2:0] op);
    return (op <= 3'b101);
  endfunction

  // Field packing: opcode rs rt rd shamt funct, or opcode rs rt imm.
  function automatic logic [31:0] encodeInstr(
    input logic [2:0]  op,
    input logic [4:0]  rsF,
    input logic [4:0]  rtF,
    input logic [4:0]  rdF,
    input logic [15:0] immF
  );
    case (op)
      3'b000:  return {6'b000000, rsF, rtF, rdF, 5'b00000, 6'b100000};
      3'b001:  return {6'b000000, rsF, rtF, rdF, 5'b00000, 6'b100010};
      3'b010:  return {6'b001000, rsF, rtF, immF};
      3'b011:  return {6'b100011, rsF, rtF, immF};
      3'b100:  return {6'b101011, rsF, rtF, immF};
      3'b101:  return {6'b011100, rsF, rtF, rdF, 5'b00000, 6'b000010};
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Handshake: a pending write that fills the memory blocks a new accept.
  always_comb begin
    lastWrite = imWe && (wordCount == LAST_CNT);
    inReady   = (state == LOAD) && !clr && !lastWrite;
    accept    = bus.in_valid && inReady;
    legal     = isLegalOp(bus.op_sel);
    encoded   = encodeInstr(bus.op_sel, bus.rs, bus.rt, bus.rd, bus.imm);
  end

  // State register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= LOAD;
    end else begin
      state <= stateNext;
    end
  end

  // Next state: fill on the DEPTH-th counted write, leave only on clear.
  always_comb begin
    stateNext = state;
    case (state)
      LOAD: begin
        if (clr) begin
          stateNext = LOAD;
        end else if (lastWrite) begin
          stateNext = FULL;
        end else begin
          stateNext = LOAD;
        end
      end
      FULL: begin
        if (clr) begin
          stateNext = LOAD;
        end else begin
          stateNext = FULL;
        end
      end
      default: stateNext = LOAD;
    endcase
  end

  // Write strobe, address and data, pointer, count and sticky error.
  // The pointer advances at accept so back-to-back requests get consecutive
  // addresses; the count advances at the end of each write cycle.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      imWe      <= 1'b0;
      imAddr    <= BASE_PTR;
      imWdata   <= 32'h0000_0000;
      writePtr  <= BASE_PTR;
      wordCount <= '0;
      errFlag   <= 1'b0;
    end else begin
      if (accept && legal) begin
        imWe    <= 1'b1;
        imAddr  <= writePtr;
        imWdata <= encoded;
      end else begin
        imWe    <= 1'b0;
      end
      if (clr) begin
        writePtr  <= BASE_PTR;
        wordCount <= '0;
        errFlag   <= 1'b0;
      end else begin
        if (accept && legal && (writePtr != LAST_PTR)) begin
          writePtr <= writePtr + ADDR_W'(1);
        end
        if (imWe) begin
          wordCount <= wordCount + (ADDR_W+1)'(1);
        end
        if (accept && !legal) begin
          errFlag <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.im_we      = imWe;
  assign bus.im_addr    = imAddr;
  assign bus.im_wdata   = imWdata;
  assign bus.word_count = wordCount;
  assign bus.full       = (state == FULL);
  assign bus.err        = errFlag;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed testbench for instr_word_encoder: one DEPTH=64 instance for the
// encoding/handshake scenarios and one DEPTH=4 instance for the full case.
module tb_instr_word_encoder;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  logic clr = 1'b0;
  logic clr4 = 1'b0;
  int   nVec = 0;
  int   nErr = 0;

  instr_word_encoder_if #(.ADDR_W(6)) bus ();
  instr_word_encoder_if #(.ADDR_W(6)) bus4 ();

  instr_word_encoder #(.ADDR_W(6), .BASE_ADDR(0), .DEPTH(64)) dut (
    .CLK(CLK), .Reset(Reset), .clr(clr), .bus(bus)
  );

  instr_word_encoder #(.ADDR_W(6), .BASE_ADDR(0), .DEPTH(4)) dut4 (
    .CLK(CLK), .Reset(Reset), .clr(clr4), .bus(bus4)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic setReq(input logic v, input logic [2:0] op, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [15:0] i);
    bus.in_valid = v; bus.op_sel = op; bus.rs = s; bus.rt = t; bus.rd = d; bus.imm = i;
  endtask

  task automatic setReq4(input logic v, input logic [2:0] op, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic [15:0] i);
    bus4.in_valid = v; bus4.op_sel = op; bus4.rs = s; bus4.rt = t; bus4.rd = d; bus4.imm = i;
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    setReq(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0000);
    setReq4(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0000);
    Reset = 1'b0;
    tick(); tick();
    nVec++; if (bus.im_we !== 1'b0) begin nErr++; $display("FAIL reset_we: got %b expected 0", bus.im_we); end
    nVec++; if (bus.im_wdata !== 32'h0) begin nErr++; $display("FAIL reset_wdata: got %h expected 0", bus.im_wdata); end
    nVec++; if (bus.im_addr !== 6'd0) begin nErr++; $display("FAIL reset_addr: got %0d expected 0", bus.im_addr); end
    nVec++; if (bus.word_count !== 7'd0) begin nErr++; $display("FAIL reset_count: got %0d expected 0", bus.word_count); end
    nVec++; if (bus.err !== 1'b0) begin nErr++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    nVec++; if (bus.full !== 1'b0) begin nErr++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    Reset = 1'b1;
    tick();
    nVec++; if (bus.in_ready !== 1'b1) begin nErr++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_single_add();
    setReq(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 16'hFFFF);
    tick();
    setReq(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0000);
    nVec++; if (bus.im_we !== 1'b1) begin nErr++; $display("FAIL add_we: got %b expected 1", bus.im_we); end
    nVec++; if (bus.im_addr !== 6'd0) begin nErr++; $display("FAIL add_addr: got %0d expected 0", bus.im_addr); end
    nVec++; if (bus.im_wdata !== 32'h00221820) begin nErr++; $display("FAIL add_wdata: got %h expected 00221820", bus.im_wdata); end
    tick();
    nVec++; if (bus.im_we !== 1'b0) begin nErr++; $display("FAIL add_we_pulse: got %b expected 0", bus.im_we); end
    nVec++; if (bus.word_count !== 7'd1) begin nErr++; $display("FAIL add_count: got %0d expected 1", bus.word_count); end
    nVec++; if (bus.im_wdata !== 32'h00221820) begin nErr++; $display("FAIL add_hold: got %h expected 00221820", bus.im_wdata); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    logic [4:0]  rss [5] = '{5'd4, 5'd0, 5'd1, 5'd1, 5'd1};
    logic [4:0]  rts [5] = '{5'd3, 5'd1, 5'd2, 5'd2, 5'd2};
    logic [4:0]  rds [5] = '{5'd5, 5'd31, 5'd31, 5'd31, 5'd4};
    logic [15:0] ims [5] = '{16'hFFFF, 16'd5, 16'd8, 16'd4, 16'hFFFF};
    logic [31:0] exps [5] = '{32'h00832822, 32'h20010005, 32'h8C220008, 32'hAC220004, 32'h70222002};
    pulseClr();
    for (int i = 0; i < 5; i++) begin
      setReq(1'b1, ops[i], rss[i], rts[i], rds[i], ims[i]);
      #1;
      nVec++; if (bus.in_ready !== 1'b1) begin nErr++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      tick();
      nVec++; if (bus.im_we !== 1'b1) begin nErr++; $display("FAIL b2b_we[%0d]: got %b expected 1", i, bus.im_we); end
      nVec++; if (bus.im_addr !== 6'(i)) begin nErr++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", i, bus.im_addr, i); end
      nVec++; if (bus.im_wdata !== exps[i]) begin nErr++; $display("FAIL b2b_wdata[%0d]: got %h expected %h", i, bus.im_wdata, exps[i]); end
    end
    setReq(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0000);
    tick();
    nVec++; if (bus.im_we !== 1'b0) begin nErr++; $display("FAIL b2b_idle_we: got %b expected 0", bus.im_we); end
    nVec++; if (bus.word_count !== 7'd5) begin nErr++; $display("FAIL b2b_count: got %0d expected 5", bus.word_count); end
  endtask

  task automatic test_illegal();
    pulseClr();
    setReq(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 16'h0000);
    tick();
    nVec++; if (bus.im_addr !== 6'd0 || bus.im_we !== 1'b1) begin nErr++; $display("FAIL ill_first: got we=%b addr=%0d expected we=1 addr=0", bus.im_we, bus.im_addr); end
    setReq(1'b1, 3'b110, 5'd1, 5'd2, 5'd3, 16'h0000);
    tick();
    nVec++; if (bus.im_we !== 1'b0) begin nErr++; $display("FAIL ill_nowrite: got %b expected 0", bus.im_we); end
    nVec++; if (bus.err !== 1'b1) begin nErr++; $display("FAIL ill_err: got %b expected 1", bus.err); end
    setReq(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 16'h0000);
    tick();
    nVec++; if (bus.im_addr !== 6'd1 || bus.im_we !== 1'b1) begin nErr++; $display("FAIL ill_second: got we=%b addr=%0d expected we=1 addr=1", bus.im_we, bus.im_addr); end
    setReq(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0000);
    tick(); tick(); tick();
    nVec++; if (bus.word_count !== 7'd2) begin nErr++; $display("FAIL ill_count: got %0d expected 2", bus.word_count); end
    nVec++; if (bus.err !== 1'b1) begin nErr++; $display("FAIL ill_sticky: got %b expected 1", bus.err); end
    pulseClr();
    nVec++; if (bus.err !== 1'b0) begin nErr++; $display("FAIL ill_clr: got %b expected 0", bus.err); end
    setReq(1'b1, 3'b111, 5'd0, 5'd0, 5'd0, 16'h0000);
    tick();
    setReq(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0000);
    nVec++; if (bus.err !== 1'b1 || bus.im_we !== 1'b0) begin nErr++; $display("FAIL ill_111: got err=%b we=%b expected err=1 we=0", bus.err, bus.im_we); end
    pulseClr();
  endtask

  task automatic test_full();
    int nWrites = 0;
    setReq4(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 16'h0000);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus4.im_we === 1'b1) begin
        nVec++; if (bus4.im_addr !== 6'(nWrites)) begin nErr++; $display("FAIL full_addr[%0d]: got %0d expected %0d", nWrites, bus4.im_addr, nWrites); end
        nWrites++;
      end
    end
    nVec++; if (nWrites != 4) begin nErr++; $display("FAIL full_writes: got %0d expected 4", nWrites); end
    nVec++; if (bus4.full !== 1'b1) begin nErr++; $display("FAIL full_flag: got %b expected 1", bus4.full); end
    nVec++; if (bus4.in_ready !== 1'b0) begin nErr++; $display("FAIL full_ready: got %b expected 0", bus4.in_ready); end
    nVec++; if (bus4.word_count !== 7'd4) begin nErr++; $display("FAIL full_count: got %0d expected 4", bus4.word_count); end
    nVec++; if (bus4.im_we !== 1'b0) begin nErr++; $display("FAIL full_we: got %b expected 0", bus4.im_we); end
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    #1;
    nVec++; if (bus4.im_we !== 1'b0 || bus4.full !== 1'b0) begin nErr++; $display("FAIL full_clr: got we=%b full=%b expected 0 0", bus4.im_we, bus4.full); end
    nVec++; if (bus4.in_ready !== 1'b1) begin nErr++; $display("FAIL full_clr_ready: got %b expected 1", bus4.in_ready); end
    tick();
    setReq4(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0000);
    nVec++; if (bus4.im_we !== 1'b1 || bus4.im_addr !== 6'd0 || bus4.im_wdata !== 32'h00221820) begin
      nErr++; $display("FAIL full_pending: got we=%b addr=%0d data=%h expected we=1 addr=0 data=00221820", bus4.im_we, bus4.im_addr, bus4.im_wdata);
    end
    tick();
  endtask

  task automatic test_clr_priority();
    pulseClr();
    setReq(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 16'h0000);
    tick();
    setReq(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0000);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    nVec++; if (bus.word_count !== 7'd0) begin nErr++; $display("FAIL clr_uncounted: got %0d expected 0", bus.word_count); end
    setReq(1'b1, 3'b000, 5'd2, 5'd3, 5'd4, 16'h0000);
    clr = 1'b1;
    #1;
    nVec++; if (bus.in_ready !== 1'b0) begin nErr++; $display("FAIL clr_ready: got %b expected 0", bus.in_ready); end
    tick();
    clr = 1'b0;
    nVec++; if (bus.im_we !== 1'b0 || bus.word_count !== 7'd0) begin nErr++; $display("FAIL clr_noaccept: got we=%b count=%0d expected 0 0", bus.im_we, bus.word_count); end
    tick();
    setReq(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0000);
    nVec++; if (bus.im_we !== 1'b1 || bus.im_addr !== 6'd0 || bus.im_wdata !== 32'h00432020) begin
      nErr++; $display("FAIL clr_next: got we=%b addr=%0d data=%h expected we=1 addr=0 data=00432020", bus.im_we, bus.im_addr, bus.im_wdata);
    end
    tick();
    nVec++; if (bus.word_count !== 7'd1) begin nErr++; $display("FAIL clr_count: got %0d expected 1", bus.word_count); end
  endtask

  task automatic test_reset_mid();
    setReq(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 16'h0000);
    tick(); tick();
    setReq(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0000);
    nVec++; if (bus.im_we !== 1'b1 || bus.im_addr !== 6'd2) begin nErr++; $display("FAIL rmid_pre: got we=%b addr=%0d expected we=1 addr=2", bus.im_we, bus.im_addr); end
    Reset = 1'b0;
    #1;
    nVec++; if (bus.im_we !== 1'b0) begin nErr++; $display("FAIL rmid_we: got %b expected 0", bus.im_we); end
    nVec++; if (bus.word_count !== 7'd0 || bus.im_addr !== 6'd0) begin nErr++; $display("FAIL rmid_state: got count=%0d addr=%0d expected 0 0", bus.word_count, bus.im_addr); end
    tick();
    Reset = 1'b1;
    setReq(1'b1, 3'b000, 5'd1, 5'd2, 5'd3, 16'h0000);
    tick();
    setReq(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 16'h0000);
    nVec++; if (bus.im_we !== 1'b1 || bus.im_addr !== 6'd0) begin nErr++; $display("FAIL rmid_first: got we=%b addr=%0d expected we=1 addr=0", bus.im_we, bus.im_addr); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_illegal();
    test_full();
    test_clr_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
